sobel_addsub_pipe: RTL and testbench

Parametrised, pipelined add/subtract/absolute-difference unit for the Sobel gradient datapath. It generalises the single-cycle ripple add/sub cell:
- the carry chain is split into STAGES registered segments;
- a valid/ready handshake is added;
- an absolute-difference mode is added for |Gx|/|Gy| computation.

It sits between the 3x3 window multiplier taps and the gradient magnitude combiner.

---
 rtl/sobel_addsub_pipe.sv | 173 +++++++++++++++++
 tb/tb_sobel_addsub_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_addsub_pipe.sv
// rtl/sobel_addsub_pipe.sv - pipelined add / subtract / absolute-difference unit for the Sobel gradient path
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready is combinational)
//   a, b                 unsigned BITWIDTH-bit operands
//   op                   00 add, 01 a-b, 10 |a-b|, 11 add
//   out_valid, out_ready output handshake
//   ans_out, cout        result and carry / no-borrow (a >= b) flag
//
// Parameters: BITWIDTH (>= 2), STAGES (must divide BITWIDTH).
// Optional macro SOBEL_ADDSUB_SAT_EN: saturating add/sub in the final stage.
// Latency is STAGES+1 cycles; the whole pipe stalls together when the output is blocked.

module sobel_addsub_pipe #(
    parameter int BITWIDTH = 8,
    parameter int STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [1:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] ans_out,
    output logic                cout
);
    localparam int CHUNK = BITWIDTH / STAGES;

    logic                advance;
    logic                sub_in;
    logic [BITWIDTH-1:0] bcomp_in;

    // Carry-segment stage registers, index k holds the result of segment k
    logic                v_q  [STAGES];
    logic                v_d  [STAGES];
    logic [1:0]          op_q [STAGES];
    logic [1:0]          op_d [STAGES];
    logic [BITWIDTH-1:0] a_q  [STAGES];
    logic [BITWIDTH-1:0] a_d  [STAGES];
    logic [BITWIDTH-1:0] bc_q [STAGES];
    logic [BITWIDTH-1:0] bc_d [STAGES];
    logic [BITWIDTH-1:0] s_q  [STAGES];
    logic [BITWIDTH-1:0] s_d  [STAGES];
    logic                c_q  [STAGES];
    logic                c_d  [STAGES];
    logic [CHUNK:0]      seg  [STAGES];

    // Final stage registers
    logic                out_valid_q;
    logic                out_valid_d;
    logic [BITWIDTH-1:0] ans_q;
    logic [BITWIDTH-1:0] ans_d;
    logic                cout_q;
    logic                cout_d;

    logic [BITWIDTH-1:0] fin_s;
    logic                fin_c;
    logic [1:0]          fin_op;
    logic                unused_operands;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1: invert b and feed the +1 as the carry-in
    assign sub_in   = (op == 2'b01) || (op == 2'b10);
    assign bcomp_in = b ^ {BITWIDTH{sub_in}};

    always_comb begin
        seg[0] = {1'b0, a[0 +: CHUNK]} + {1'b0, bcomp_in[0 +: CHUNK]}
               + {{CHUNK{1'b0}}, sub_in};
        for (int k = 1; k < STAGES; k++) begin
            seg[k] = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]} + {1'b0, bc_q[k-1][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_q[k-1]};
        end
    end

    always_comb begin
        v_d  = v_q;
        op_d = op_q;
        a_d  = a_q;
        bc_d = bc_q;
        s_d  = s_q;
        c_d  = c_q;
        if (advance) begin
            v_d[0]              = in_valid;
            op_d[0]             = op;
            a_d[0]              = a;
            bc_d[0]             = bcomp_in;
            s_d[0]              = '0;
            s_d[0][0 +: CHUNK]  = seg[0][CHUNK-1:0];
            c_d[0]              = seg[0][CHUNK];
            for (int k = 1; k < STAGES; k++) begin
                v_d[k]                  = v_q[k-1];
                op_d[k]                 = op_q[k-1];
                a_d[k]                  = a_q[k-1];
                bc_d[k]                 = bc_q[k-1];
                s_d[k]                  = s_q[k-1];
                s_d[k][k*CHUNK +: CHUNK] = seg[k][CHUNK-1:0];
                c_d[k]                  = seg[k][CHUNK];
            end
        end
    end

    assign fin_s  = s_q[STAGES-1];
    assign fin_c  = c_q[STAGES-1];
    assign fin_op = op_q[STAGES-1];

    always_comb begin
        out_valid_d = out_valid_q;
        ans_d       = ans_q;
        cout_d      = cout_q;
        if (advance) begin
            out_valid_d = v_q[STAGES-1];
            cout_d      = fin_c;
            ans_d       = fin_s;
            // No carry out means a < b, so the raw sum is the two's complement of |a-b|
            if (fin_op == 2'b10 && !fin_c) begin
                ans_d = ~fin_s + BITWIDTH'(1);
            end
`ifdef SOBEL_ADDSUB_SAT_EN
            if ((fin_op == 2'b00 || fin_op == 2'b11) && fin_c) begin
                ans_d = '1;
            end
            if (fin_op == 2'b01 && !fin_c) begin
                ans_d = '0;
            end
`endif
        end
    end

    // Operand chunks already summed have no further reader; fold them here to make that explicit
    always_comb begin
        unused_operands = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_operands = unused_operands ^ (^a_q[k]) ^ (^bc_q[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                op_q[k] <= 2'b00;
                a_q[k]  <= '0;
                bc_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            op_q        <= op_d;
            a_q         <= a_d;
            bc_q        <= bc_d;
            s_q         <= s_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            ans_q       <= ans_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ans_out   = ans_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_sobel_addsub_pipe.sv
// tb/tb_sobel_addsub_pipe.sv - self-checking bench for sobel_addsub_pipe
module tb_sobel_addsub_pipe;
    localparam int W   = 8;
    localparam int ST  = 2;
    localparam int L   = ST + 1;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ans_out;
    logic         cout;

    typedef struct {
        logic [W-1:0] ans;
        logic         cout;
        int           age;
    } item_t;

    item_t sb[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_fail = 0;

    sobel_addsub_pipe #(.BITWIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans_out   (ans_out),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic item_t model(input int x, input int y, input logic [1:0] o);
        item_t r;
        int    s;
        r.age = 0;
        case (o)
            2'b01: begin
                r.cout = (x >= y);
                r.ans  = W'((x - y + MOD) % MOD);
`ifdef SOBEL_ADDSUB_SAT_EN
                if (x < y) r.ans = '0;
`endif
            end
            2'b10: begin
                r.cout = (x >= y);
                r.ans  = W'((x >= y) ? (x - y) : (y - x));
            end
            default: begin
                s      = x + y;
                r.cout = (s >= MOD);
                r.ans  = W'(s % MOD);
`ifdef SOBEL_ADDSUB_SAT_EN
                if (s >= MOD) r.ans = '1;
`endif
            end
        endcase
        return r;
    endfunction

    // One clock cycle: called just after a falling edge, returns at the next falling edge.
    // An item becomes visible once it has advanced L times; the head is held while blocked.
    task automatic cycle(input logic iv, input int ia, input int ib, input logic [1:0] iop,
                         input logic ordy, output logic acc);
        logic ev;
        logic adv;
        in_valid  = iv;
        a         = W'(ia);
        b         = W'(ib);
        op        = iop;
        out_ready = ordy;
        #1;
        ev  = (sb.size() > 0) && (sb[0].age >= L);
        adv = !ev || ordy;
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(adv));
        if (ev) begin
            check("ans_out", 32'(ans_out), 32'(sb[0].ans));
            check("cout", 32'(cout), 32'(sb[0].cout));
        end
        acc = iv && adv;
        if (adv) begin
            if (ev) void'(sb.pop_front());
            if (iv) sb.push_back(model(ia, ib, iop));
            foreach (sb[i]) sb[i].age++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 2'b00, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   nxt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_ans_out", 32'(ans_out), 32'(0));
        check("reset_cout", 32'(cout), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        idle(2);

        // Add, subtract both ways, absdiff back-to-back, op 11, boundaries
        cycle(1'b1, 200, 100, 2'b00, 1'b1, acc);
        idle(L + 1);
        cycle(1'b1, 50, 80, 2'b01, 1'b1, acc);
        idle(1);
        cycle(1'b1, 80, 50, 2'b01, 1'b1, acc);
        idle(L + 1);
        cycle(1'b1, 50, 80, 2'b10, 1'b1, acc);
        cycle(1'b1, 80, 50, 2'b10, 1'b1, acc);
        cycle(1'b1, 7, 7, 2'b10, 1'b1, acc);
        cycle(1'b1, 3, 4, 2'b11, 1'b1, acc);
        cycle(1'b1, 255, 255, 2'b00, 1'b1, acc);
        cycle(1'b1, 0, 255, 2'b10, 1'b1, acc);
        cycle(1'b1, 255, 0, 2'b10, 1'b1, acc);
        cycle(1'b1, 0, 255, 2'b01, 1'b1, acc);
        cycle(1'b1, 0, 0, 2'b10, 1'b1, acc);
        idle(L + 2);

        // Backpressure: a=1..6, b=1, out_ready low on cycles 4-7; inputs retried until taken
        nxt = 1;
        for (int c = 1; c <= 25; c++) begin
            cycle(nxt <= 6, nxt, 1, 2'b00, !(c >= 4 && c <= 7), acc);
            if (acc) nxt++;
        end
        check("bp_all_accepted", 32'(nxt), 32'(7));
        idle(L + 1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(3) != 0, int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                  2'($urandom), $urandom_range(9) < 7, acc);
        end
        idle(2 * L + 4);

        // Asynchronous reset with three transactions in flight
        cycle(1'b1, 200, 100, 2'b00, 1'b1, acc);
        cycle(1'b1, 50, 80, 2'b01, 1'b1, acc);
        cycle(1'b1, 80, 50, 2'b10, 1'b1, acc);
        check("pre_rst_out_valid", 32'(out_valid), 32'(1));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'(0));
        check("async_rst_ans_out", 32'(ans_out), 32'(0));
        check("async_rst_cout", 32'(cout), 32'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(L + 3);
        cycle(1'b1, 9, 4, 2'b10, 1'b1, acc);
        idle(L + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
